// File: rtl/esc_pwm_driver.sv
// Four-channel ESC PWM driver: frame-aligned pulses whose width tracks a
// slew-limited applied speed, armed by the first speed write.
module esc_pwm_driver #(
    parameter int unsigned PERIOD_WIDTH = 20,
    parameter logic [13:0] OFF          = 14'd6250,
    parameter logic [10:0] SLEW         = 11'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        armed,
    output logic        frm_tick
);

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } state_t;

    localparam int unsigned CW = (PERIOD_WIDTH > 14) ? PERIOD_WIDTH : 14;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [PERIOD_WIDTH-1:0] w_cnt_nxt;
    logic [CW-1:0]           w_pos;
    logic                    w_wrap;
    logic                    w_step;
    logic [10:0]             w_spd         [4];
    logic [10:0]             w_slew_tgt    [4];
    logic [10:0]             w_applied_nxt [4];
    logic [13:0]             w_width_nxt   [4];
    logic [3:0]              w_pwm_nxt;
    logic [10:0]             r_target      [4];
    logic [10:0]             r_applied     [4];
    logic [13:0]             r_width       [4];
    logic [3:0]              r_pwm;
    logic                    r_pulse_en;
    logic                    r_frm_tick;

    function automatic logic [10:0] slew_step(input logic [10:0] tgt, input logic [10:0] cur);
        logic [10:0] diff;
        diff = '0;
        if (tgt > cur) begin
            diff = tgt - cur;
            if (diff > SLEW) diff = SLEW;
            return cur + diff;
        end else if (tgt < cur) begin
            diff = cur - tgt;
            if (diff > SLEW) diff = SLEW;
            return cur - diff;
        end
        return cur;
    endfunction

    assign w_spd[0]  = frnt_spd;
    assign w_spd[1]  = bck_spd;
    assign w_spd[2]  = lft_spd;
    assign w_spd[3]  = rght_spd;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_pos     = CW'(w_cnt_nxt);
    assign w_wrap    = &r_cnt;
    assign w_step    = w_wrap && (r_state == ARMED);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DISARMED: if (wrt) w_state_nxt = ARMED;
            ARMED:    w_state_nxt = ARMED;
            default:  w_state_nxt = DISARMED;
        endcase
    end

    // A write landing on the wrap edge steers this frame's slew step directly.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_slew_tgt[i]    = wrt ? w_spd[i] : r_target[i];
            w_applied_nxt[i] = slew_step(w_slew_tgt[i], r_applied[i]);
            w_width_nxt[i]   = 14'(w_applied_nxt[i]) * 14'd3 + OFF;
        end
    end

    // Width is frozen at the wrap edge; output is high for cnt in 1..W.
    always_comb begin
        w_pwm_nxt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_pwm_nxt[i] = r_pulse_en && !w_wrap && (w_pos <= CW'(r_width[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= DISARMED;
            r_cnt      <= '0;
            r_pulse_en <= 1'b0;
            r_frm_tick <= 1'b0;
            r_pwm      <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_target[i]  <= '0;
                r_applied[i] <= '0;
                r_width[i]   <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_frm_tick <= w_wrap;
            r_pwm      <= w_pwm_nxt;
            if (w_wrap) r_pulse_en <= (r_state == ARMED);
            for (int unsigned i = 0; i < 4; i++) begin
                if (wrt) r_target[i] <= w_spd[i];
                if (w_step) begin
                    r_applied[i] <= w_applied_nxt[i];
                    r_width[i]   <= w_width_nxt[i];
                end
            end
        end
    end

    assign frnt     = r_pwm[0];
    assign bck      = r_pwm[1];
    assign lft      = r_pwm[2];
    assign rght     = r_pwm[3];
    assign armed    = (r_state == ARMED);
    assign frm_tick = r_frm_tick;

endmodule

// File: doc/esc_pwm_driver.md
ESC_PWM_DRIVER -- requirements
Module: esc_pwm_driver

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 20, meaning frame counter width; frame = 2^PERIOD_WIDTH clk cycles.
REQ-002 SHALL have parameter OFF, default 14'd6250, meaning minimum pulse width in clk cycles.
REQ-003 SHALL have parameter SLEW, default 11'd64, meaning maximum per-frame change of applied speed.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wrt  input  1  one-cycle strobe that captures new target speeds.
REQ-007 SHALL have ports frnt_spd, bck_spd, lft_spd, rght_spd  input  11 each  unsigned target motor speeds from flight control.
REQ-008 SHALL have ports frnt, bck, lft, rght  output  1 each  registered PWM pulse to each ESC.
REQ-009 SHALL have port armed  output  1  high once the first wrt has been accepted.
REQ-010 SHALL have port frm_tick  output  1  one-cycle pulse on the cycle the frame counter holds 0.

Function
REQ-011 SHALL run a free-running PERIOD_WIDTH-bit frame counter cnt, incrementing every cycle and wrapping from all-ones to 0.
REQ-012 SHALL latch all four speed inputs into target registers on any cycle wrt=1, regardless of frame position.
REQ-013 SHALL implement two states: DISARMED (after reset) and ARMED; wrt=1 in DISARMED moves to ARMED on the next edge; ARMED is left only by reset.
REQ-014 SHALL hold frnt, bck, lft, rght low in DISARMED.
REQ-015 SHALL, per channel, keep an 11-bit applied speed, reset to 0, updated only at the edge where cnt wraps to 0 and only in ARMED.
REQ-016 SHALL update applied as: if target > applied, applied + min(SLEW, target - applied); if target < applied, applied - min(SLEW, applied - target); else unchanged.
REQ-017 SHALL, if wrt and the wrap edge coincide, use the newly written target for that frame's slew step.
REQ-018 SHALL compute pulse width W = applied*3 + OFF in 14-bit unsigned arithmetic, using the applied value updated at that wrap edge.
REQ-019 SHALL drive each PWM output high for exactly W consecutive cycles, starting on the cycle cnt==1, then low for the remainder of the frame.
REQ-020 SHALL generate no PWM pulse in a frame whose wrap edge occurred while DISARMED; the first pulse starts in the first frame that begins in ARMED.
REQ-021 SHALL NOT change pulse width mid-frame; wrt during a high pulse affects only the next frame.
REQ-022 SHALL require 2^PERIOD_WIDTH > 2047*3 + OFF + 2; behaviour outside this is undefined.
REQ-023 SHALL keep all four channels phase-aligned: pulses rise on the same cycle.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear cnt, targets, applied speeds, state (DISARMED), armed, frm_tick and all PWM outputs to 0.
REQ-025 SHALL, on reset mid-pulse, drop PWM outputs low immediately, without waiting for a clock edge.
REQ-026 SHALL resume counting from cnt=0 on the first rising edge after rst_n deasserts.

Verification (PERIOD_WIDTH=15, OFF=6250, SLEW=64 unless noted)
REQ-027 SHALL check: reset, no wrt for 3 frames -> PWM outputs always low, armed=0, frm_tick every 32768 cycles.
REQ-028 SHALL check: wrt with all speeds=64 -> armed=1; first ARMED frame pulse exactly 6442 cycles high; every later frame the same.
REQ-029 SHALL check: wrt with frnt_spd=2047, others 0 -> frnt widths 6442, 6634, ... rising by 192 per frame, reaching 12391 in frame 32 and holding; others 6250.
REQ-030 SHALL check: from applied=100, wrt speed=90 -> next frame width 6520, then constant.
REQ-031 SHALL check: wrt asserted on the wrap-edge cycle with speed=10 from applied 0 -> that frame width 6280.
REQ-032 SHALL check: rst_n asserted 100 cycles into a pulse -> outputs low in the same cycle, armed=0, and no pulse until a new wrt.
